// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and sizing helpers.
package serial_subtractor_pkg;

  // Encoding 2'd3 is never produced; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) behind a start/ready/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             fs_d;
  logic             fs_bout;
  logic             done_q;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at D[0].
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = fs_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          borrow <= fs_bout;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state  <= S_DONE;
            D      <= res_next;
            Bout   <= fs_bout;
            done_q <= 1'b1;
          end
        end
        // IDLE, DONE and the unused encoding all accept a new operation.
        default: begin
          if (start) begin
            state  <= S_BUSY;
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bin;
            cnt    <= '0;
          end else begin
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready = (state != S_BUSY);
  assign busy  = (state == S_BUSY);
  assign done  = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, Bin;
  logic [7:0] A, B;
  logic       ready, busy, done, Bout;
  logic [7:0] D;

  logic       start1, Bin1;
  logic [0:0] A1, B1, D1;
  logic       ready1, busy1, done1, Bout1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb [$];
  logic [1:0] sb1 [$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .ready(ready), .busy(busy), .done(done), .D(D), .Bout(Bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Bin(Bin1),
    .ready(ready1), .busy(busy1), .done(done1), .D(D1), .Bout(Bout1)
  );

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one accept edge and records the expected result; returns just after that edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    start = 1'b1; A = a; B = b; Bin = bin;
    sb.push_back(model(a, b, bin));
    step();
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
  endtask

  // Counts clocks (accept cycle = 1) until done is seen, bounded.
  task automatic wait_done(input int n0, output int n, output bit ok);
    n = n0; ok = 1'b0;
    while (n < 40 && !ok) begin
      step();
      n++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 8'h5A; B = 8'h3C; Bin = 1'b0;
    start1 = 1'b0; A1 = 1'b0; B1 = 1'b0; Bin1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy);
      end
    end
    n_cmp++;
    if ({ready, busy, done, Bout, D} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b Bout=%b D=%h want 1 0 0 0 00",
               ready, busy, done, Bout, D);
    end
    start = 1'b0; rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release: busy=%b ready=%b want 0 1", busy, ready);
    end
  endtask

  task automatic test_basic();
    int n; bit ok; logic [8:0] exp;
    launch(8'h5A, 8'h3C, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy: busy=%b ready=%b want 1 0", busy, ready);
    end
    wait_done(1, n, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || n !== 9) begin
      n_bad++; $display("FAIL basic_latency: got %0d clocks (seen=%b) want 9", n, ok);
    end
    n_cmp++;
    if ({Bout, D} !== exp) begin
      n_bad++; $display("FAIL basic_result: got %b_%h want %b_%h", Bout, D, exp[8], exp[7:0]);
    end
    repeat (3) step();
    n_cmp++;
    if ({done, Bout, D} !== {1'b0, exp}) begin
      n_bad++; $display("FAIL basic_hold: done=%b Bout=%b D=%h want 0 %b %h", done, Bout, D, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ta [3] = '{8'h00, 8'h10, 8'hFF};
    logic [7:0] tb [3] = '{8'h01, 8'h10, 8'h00};
    logic       tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] tx [3] = '{9'h1FF, 9'h1FF, 9'h0FE};
    int n; bit ok; logic [8:0] exp;
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(1, n, ok);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || {Bout, D} !== exp || exp !== tx[i]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: seen=%b got %b_%h want %b_%h", i, ok, Bout, D, tx[i][8], tx[i][7:0]);
      end
      step();
    end
  endtask

  task automatic test_busy_start();
    int n; bit ok; logic [8:0] exp;
    launch(8'h5A, 8'h3C, 1'b0);
    step(); step();
    start = 1'b1; A = 8'h01; B = 8'h01; Bin = 1'b0;
    step(); step();
    start = 1'b0;
    wait_done(5, n, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || n !== 9 || {Bout, D} !== exp) begin
      n_bad++; $display("FAIL busy_start: seen=%b clocks=%0d got %b_%h want %b_%h",
                        ok, n, Bout, D, exp[8], exp[7:0]);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_extra: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; logic [8:0] exp;
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done(1, n, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || {Bout, D} !== exp || ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: seen=%b ready=%b got %b_%h want %b_%h",
                        ok, ready, Bout, D, exp[8], exp[7:0]);
    end
    launch(8'h09, 8'h04, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || D !== exp[7:0]) begin
      n_bad++; $display("FAIL b2b_accept: busy=%b D=%h want 1 %h", busy, D, exp[7:0]);
    end
    wait_done(1, n, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || n !== 9 || {Bout, D} !== exp) begin
      n_bad++; $display("FAIL b2b_second: seen=%b clocks=%0d got %b_%h want %b_%h",
                        ok, n, Bout, D, exp[8], exp[7:0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n; bit ok; int pulses; logic [8:0] exp;
    launch(8'h33, 8'h11, 1'b0);
    void'(sb.pop_back());
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ready, done, Bout, D} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL reset_mid_state: ready=%b done=%b Bout=%b D=%h want 1 0 0 00",
                        ready, done, Bout, D);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_abort: done pulses=%0d busy=%b want 0 0", pulses, busy);
    end
    launch(8'hC3, 8'h5E, 1'b1);
    wait_done(1, n, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || n !== 9 || {Bout, D} !== exp) begin
      n_bad++; $display("FAIL reset_mid_recover: seen=%b clocks=%0d got %b_%h want %b_%h",
                        ok, n, Bout, D, exp[8], exp[7:0]);
    end
    step();
  endtask

  task automatic test_width1();
    logic [2:0] v; logic [1:0] exp; int n; bit ok;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      start1 = 1'b1; A1 = v[2]; B1 = v[1]; Bin1 = v[0];
      sb1.push_back({1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]});
      step();
      start1 = 1'b0;
      n = 1; ok = 1'b0;
      while (n < 10 && !ok) begin
        step();
        n++;
        if (done1) ok = 1'b1;
      end
      exp = sb1.pop_front();
      n_cmp++;
      if (!ok || n !== 2 || {Bout1, D1} !== exp) begin
        n_bad++; $display("FAIL width1[a=%b b=%b bin=%b]: seen=%b clocks=%0d got %b%b want %b",
                          v[2], v[1], v[0], ok, n, Bout1, D1, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
